// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID prefetch queue.
// slave is the queue's view; master is the fetch/decode (or bench) view.
interface if_id_queue_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 4
);
    logic                     push_valid_i;
    logic                     push_ready_o;
    logic [PC_W-1:0]          push_pc_i;
    logic [INSTR_W-1:0]       push_instr_i;
    logic                     pop_valid_o;
    logic                     pop_ready_i;
    logic [PC_W-1:0]          pop_pc_o;
    logic [INSTR_W-1:0]       pop_instr_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport slave (
        input  push_valid_i, push_pc_i, push_instr_i, pop_ready_i,
        output push_ready_o, pop_valid_o, pop_pc_o, pop_instr_o, count_o
    );

    modport master (
        output push_valid_i, push_pc_i, push_instr_i, pop_ready_i,
        input  push_ready_o, pop_valid_o, pop_pc_o, pop_instr_o, count_o
    );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry IF/ID instruction prefetch queue with first-word-fall-through head and flush.
// Define IF_ID_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass path.
module if_id_queue #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 DEPTH     = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    if_id_queue_if.slave  q_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PC_W-1:0]    pc_mem_q    [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic               empty;
    logic               push_ready;
    logic               pop_valid;
    logic               push_fire;
    logic               pop_fire;
    logic               bypass_take;
    logic               store_push;
    logic               read_pop;
    logic [PC_W-1:0]    head_pc;
    logic [INSTR_W-1:0] head_instr;

    always_comb begin
        empty      = (count_q == '0);
        push_ready = (count_q != FULL_CNT);
        pop_valid  = !empty;
        head_pc    = empty ? '0        : pc_mem_q[rd_ptr_q];
        head_instr = empty ? NOP_INSTR : instr_mem_q[rd_ptr_q];
        bypass_take = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
        // Empty queue: present the incoming entry straight to decode.
        if (empty && q_if.push_valid_i && !flush_i) begin
            pop_valid   = 1'b1;
            head_pc     = q_if.push_pc_i;
            head_instr  = q_if.push_instr_i;
            bypass_take = q_if.pop_ready_i;
        end
`endif
        push_fire  = q_if.push_valid_i & push_ready & !flush_i;
        pop_fire   = pop_valid & q_if.pop_ready_i & !flush_i;
        // A bypassed entry is consumed in flight and never touches storage.
        store_push = push_fire & !bypass_take;
        read_pop   = pop_fire  & !bypass_take;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (read_pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (store_push && !read_pop)      count_d = count_q + CNT_W'(1);
            else if (!store_push && read_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store_push) begin
            pc_mem_q[wr_ptr_q]    <= q_if.push_pc_i;
            instr_mem_q[wr_ptr_q] <= q_if.push_instr_i;
        end
    end

    assign q_if.push_ready_o = push_ready;
    assign q_if.pop_valid_o  = pop_valid;
    assign q_if.pop_pc_o     = head_pc;
    assign q_if.pop_instr_o  = head_instr;
    assign q_if.count_o      = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4, 32-bit fields).
module tb_if_id_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    if_id_queue_if #(.PC_W(32), .INSTR_W(32), .DEPTH(4)) q_if ();

    if_id_queue #(.PC_W(32), .INSTR_W(32), .DEPTH(4), .NOP_INSTR(32'h00000013)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .q_if    (q_if.slave)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle inputs/outputs away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        q_if.push_valid_i = 1'b0;
        q_if.pop_ready_i  = 1'b0;
        q_if.push_pc_i    = 32'h0;
        q_if.push_instr_i = 32'h0;
        flush = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
        q_if.push_valid_i = 1'b1;
        q_if.push_pc_i    = pc;
        q_if.push_instr_i = instr;
        tick();
        q_if.push_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (q_if.pop_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_pop_valid: got %0b want 0", q_if.pop_valid_o); end
        n_checks++; if (q_if.pop_instr_o !== 32'h00000013) begin n_fail++; $display("FAIL reset_pop_instr: got %h want 00000013", q_if.pop_instr_o); end
        n_checks++; if (q_if.pop_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pop_pc: got %h want 00000000", q_if.pop_pc_o); end
        n_checks++; if (q_if.count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", q_if.count_o); end
        n_checks++; if (q_if.push_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready: got %0b want 1", q_if.push_ready_o); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push_one(32'(i * 4), 32'hA0 + 32'(i));
        n_checks++; if (q_if.count_o !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", q_if.count_o); end
        n_checks++; if (q_if.push_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_push_ready: got %0b want 0", q_if.push_ready_o); end
        push_one(32'h10, 32'hA4);
        n_checks++; if (q_if.count_o !== 3'd4) begin n_fail++; $display("FAIL fill_reject_count: got %0d want 4", q_if.count_o); end
        n_checks++; if (q_if.pop_pc_o !== 32'h00 || q_if.pop_instr_o !== 32'hA0) begin n_fail++; $display("FAIL fill_head: got pc %h instr %h want 00000000 000000a0", q_if.pop_pc_o, q_if.pop_instr_o); end
        // Pop while full: the offered push is still refused this cycle.
        q_if.push_valid_i = 1'b1;
        q_if.push_pc_i    = 32'h10;
        q_if.push_instr_i = 32'hA4;
        q_if.pop_ready_i  = 1'b1;
        tick();
        q_if.push_valid_i = 1'b0;
        q_if.pop_ready_i  = 1'b0;
        n_checks++; if (q_if.count_o !== 3'd3) begin n_fail++; $display("FAIL full_pop_count: got %0d want 3", q_if.count_o); end
        n_checks++; if (q_if.push_ready_o !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %0b want 1", q_if.push_ready_o); end
        n_checks++; if (q_if.pop_pc_o !== 32'h04) begin n_fail++; $display("FAIL full_pop_head: got %h want 00000004", q_if.pop_pc_o); end
    endtask

    task automatic test_drain_wrap();
        logic [31:0] exp_pc [5];
        exp_pc = '{32'h08, 32'h0C, 32'h10, 32'h14, 32'h0};
        // Second entry of the original fill leaves here; the first left at full.
        q_if.pop_ready_i = 1'b1;
        tick();
        q_if.pop_ready_i = 1'b0;
        push_one(32'h10, 32'hA4);
        push_one(32'h14, 32'hA5);
        n_checks++; if (q_if.count_o !== 3'd4) begin n_fail++; $display("FAIL wrap_count_full: got %0d want 4", q_if.count_o); end
        q_if.pop_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (q_if.pop_valid_o !== 1'b1 || q_if.pop_pc_o !== exp_pc[i] || q_if.pop_instr_o !== 32'hA2 + 32'(i)) begin
                n_fail++;
                $display("FAIL wrap_order_%0d: got v%0b pc %h instr %h want v1 pc %h instr %h", i, q_if.pop_valid_o, q_if.pop_pc_o, q_if.pop_instr_o, exp_pc[i], 32'hA2 + 32'(i));
            end
            tick();
        end
        q_if.pop_ready_i = 1'b0;
        n_checks++; if (q_if.count_o !== 3'd0 || q_if.pop_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_empty: got count %0d valid %0b want 0 0", q_if.count_o, q_if.pop_valid_o); end
    endtask

    task automatic test_simul();
        push_one(32'h18, 32'hB0);
        push_one(32'h1C, 32'hB1);
        q_if.push_valid_i = 1'b1;
        q_if.push_pc_i    = 32'h20;
        q_if.push_instr_i = 32'hB2;
        q_if.pop_ready_i  = 1'b1;
        #1;
        n_checks++; if (q_if.pop_pc_o !== 32'h18) begin n_fail++; $display("FAIL simul_head_before: got %h want 00000018", q_if.pop_pc_o); end
        tick();
        q_if.push_valid_i = 1'b0;
        n_checks++; if (q_if.count_o !== 3'd2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", q_if.count_o); end
        n_checks++; if (q_if.pop_pc_o !== 32'h1C) begin n_fail++; $display("FAIL simul_head_next: got %h want 0000001c", q_if.pop_pc_o); end
        tick();
        n_checks++; if (q_if.pop_pc_o !== 32'h20 || q_if.pop_instr_o !== 32'hB2) begin n_fail++; $display("FAIL simul_tail: got pc %h instr %h want 00000020 000000b2", q_if.pop_pc_o, q_if.pop_instr_o); end
        tick();
        q_if.pop_ready_i = 1'b0;
        n_checks++; if (q_if.count_o !== 3'd0) begin n_fail++; $display("FAIL simul_drained: got %0d want 0", q_if.count_o); end
    endtask

    task automatic test_flush();
        push_one(32'h30, 32'hC0);
        push_one(32'h34, 32'hC1);
        push_one(32'h38, 32'hC2);
        flush = 1'b1;
        q_if.push_valid_i = 1'b1;
        q_if.push_pc_i    = 32'h40;
        q_if.push_instr_i = 32'hC3;
        q_if.pop_ready_i  = 1'b1;
        #1;
        n_checks++; if (q_if.pop_valid_o !== 1'b1 || q_if.pop_pc_o !== 32'h30 || q_if.count_o !== 3'd3) begin n_fail++; $display("FAIL flush_cycle_view: got v%0b pc %h count %0d want v1 pc 00000030 count 3", q_if.pop_valid_o, q_if.pop_pc_o, q_if.count_o); end
        tick();
        flush = 1'b0;
        q_if.push_valid_i = 1'b0;
        q_if.pop_ready_i  = 1'b0;
        n_checks++; if (q_if.count_o !== 3'd0 || q_if.pop_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got count %0d valid %0b want 0 0", q_if.count_o, q_if.pop_valid_o); end
        n_checks++; if (q_if.pop_instr_o !== 32'h00000013) begin n_fail++; $display("FAIL flush_nop: got %h want 00000013", q_if.pop_instr_o); end
        push_one(32'h44, 32'hC4);
        n_checks++; if (q_if.pop_pc_o !== 32'h44 || q_if.count_o !== 3'd1) begin n_fail++; $display("FAIL flush_dropped_push: got pc %h count %0d want 00000044 1", q_if.pop_pc_o, q_if.count_o); end
        q_if.pop_ready_i = 1'b1;
        tick();
        q_if.pop_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_one(32'h50, 32'hD0);
        push_one(32'h54, 32'hD1);
        n_checks++; if (q_if.count_o !== 3'd2) begin n_fail++; $display("FAIL rstmid_setup: got %0d want 2", q_if.count_o); end
        rst = 1'b1;
        flush = 1'b1;
        q_if.push_valid_i = 1'b1;
        q_if.push_pc_i    = 32'h58;
        q_if.push_instr_i = 32'hD2;
        q_if.pop_ready_i  = 1'b1;
        tick();
        idle();
        #1;
        n_checks++; if (q_if.count_o !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", q_if.count_o); end
        n_checks++; if (q_if.pop_instr_o !== 32'h00000013 || q_if.pop_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_head: got instr %h valid %0b want 00000013 0", q_if.pop_instr_o, q_if.pop_valid_o); end
    endtask

    task automatic test_bypass();
        q_if.push_valid_i = 1'b1;
        q_if.push_pc_i    = 32'h80;
        q_if.push_instr_i = 32'hE0;
        q_if.pop_ready_i  = 1'b1;
        #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
        n_checks++; if (q_if.pop_valid_o !== 1'b1 || q_if.pop_pc_o !== 32'h80) begin n_fail++; $display("FAIL bypass_same_cycle: got v%0b pc %h want v1 pc 00000080", q_if.pop_valid_o, q_if.pop_pc_o); end
        tick();
        q_if.push_valid_i = 1'b0;
        q_if.pop_ready_i  = 1'b0;
        n_checks++; if (q_if.count_o !== 3'd0) begin n_fail++; $display("FAIL bypass_count: got %0d want 0", q_if.count_o); end
`else
        n_checks++; if (q_if.pop_valid_o !== 1'b0) begin n_fail++; $display("FAIL nobypass_same_cycle: got v%0b want v0", q_if.pop_valid_o); end
        tick();
        q_if.push_valid_i = 1'b0;
        q_if.pop_ready_i  = 1'b0;
        #1;
        n_checks++; if (q_if.pop_pc_o !== 32'h80 || q_if.count_o !== 3'd1) begin n_fail++; $display("FAIL nobypass_next: got pc %h count %0d want 00000080 1", q_if.pop_pc_o, q_if.count_o); end
        q_if.pop_ready_i = 1'b1;
        tick();
        q_if.pop_ready_i = 1'b0;
        n_checks++; if (q_if.count_o !== 3'd0) begin n_fail++; $display("FAIL nobypass_drain: got %0d want 0", q_if.count_o); end
`endif
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simul();
        test_flush();
        test_reset_mid();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
